// File: rtl/msk_fifo_en.sv
// msk_fifo_en: masked circular FIFO with valid/ready handshake, flush and share-wise output gating
module msk_fifo_en #(
  parameter int d = 1,
  parameter int count = 1,
  parameter int DEPTH = 2,
  localparam int W = count * d,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] level
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic push, pop;
  always_comb begin
    in_ready = level != LW'(DEPTH);
    out_valid = level != '0;
    out_data = mem[rd_ptr] & {W{out_valid}};
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    wr_next = wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
    rd_next = rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr <= wr_next;
      end
      if (pop) rd_ptr <= rd_next;
      level <= push & !pop ? level + 1'b1 : pop & !push ? level - 1'b1 : level;
    end
  end
endmodule

// File: tb/tb_msk_fifo_en.sv
// tb_msk_fifo_en: directed self-checking bench for msk_fifo_en with DEPTH=3, d=2, count=4
module tb_msk_fifo_en;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] level;
  int total = 0, passed = 0;
  logic [7:0] prev;
  msk_fifo_en #(.d(2), .count(4), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] v);
    in_valid = 1;
    in_data = v;
    step();
    in_valid = 0;
  endtask
  initial begin
    in_valid = 1;
    in_data = 8'hEE;
    step();
    step();
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    rst = 0;
    in_valid = 0;
    push(8'hA5);
    push(8'h3C);
    push(8'hFF);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_level", level, 3);
    out_ready = 1;
    chk("drain0", out_data, 8'hA5);
    step();
    chk("drain1", out_data, 8'h3C);
    step();
    chk("drain2", out_data, 8'hFF);
    step();
    chk("drain_level", level, 0);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_out_data", out_data, 0);
    out_ready = 0;
    push(8'h10);
    out_ready = 1;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1;
      in_data = 8'h10 + 8'(k);
      chk("wrap_data", out_data, 8'h10 + 8'(k) - 8'h1);
      step();
      chk("wrap_level", level, 1);
    end
    in_valid = 0;
    chk("wrap_last", out_data, 8'h1A);
    step();
    chk("wrap_empty", level, 0);
    out_ready = 0;
    push(8'h21);
    push(8'h22);
    push(8'h23);
    in_valid = 1;
    in_data = 8'h24;
    out_ready = 1;
    chk("full_in_ready", in_ready, 0);
    chk("full_pop_data", out_data, 8'h21);
    step();
    in_valid = 0;
    chk("full_level", level, 2);
    chk("full_next", out_data, 8'h22);
    step();
    chk("full_next2", out_data, 8'h23);
    step();
    chk("full_refused", out_valid, 0);
    out_ready = 0;
    push(8'h31);
    push(8'h32);
    chk("pre_flush_level", level, 2);
    flush = 1;
    in_valid = 1;
    in_data = 8'h33;
    out_ready = 1;
    chk("flush_in_ready", in_ready, 1);
    step();
    flush = 0;
    in_valid = 0;
    chk("flush_level", level, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, 0);
    push(8'h11);
    chk("flush_first", out_data, 8'h11);
    step();
    chk("flush_empty", level, 0);
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1;
      in_data = 8'hAA | ((k % 2) == 1 ? 8'h55 : 8'h00);
      if (k > 0) begin
        chk("iso_data", out_data, prev);
        chk("iso_other_shares", out_data & 8'hAA, 8'hAA);
      end
      step();
      prev = in_data;
    end
    in_valid = 0;
    chk("iso_last", out_data, prev);
    step();
    chk("iso_empty", level, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
